pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 91 +++++++++
 tb/tb_pc_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch front end: owns the PC, issues one memory request at a time,
// holds the fetched word until decode accepts it, and traps on misaligned redirects.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  input  logic [31:0] i_pc_plus4,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        redirect_misaligned;

  assign redirect_misaligned = (i_redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_FETCH: begin
        // A redirect wins over a same-cycle ack; the returned word is discarded.
        if (i_redirect) begin
          pc_d    = i_redirect_pc;
          state_d = redirect_misaligned ? S_FAULT : S_FETCH;
        end else if (i_imem_ack) begin
          instr_d = i_imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          pc_d    = i_redirect_pc;
          state_d = redirect_misaligned ? S_FAULT : S_FETCH;
        end else if (i_instr_ready) begin
          pc_d    = i_pc_plus4;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Request is gated by reset so memory never sees a fetch while reset is held.
  assign o_imem_req    = (state_q == S_FETCH) & i_rst_n;
  assign o_instr_valid = (state_q == S_HOLD);
  assign o_fault       = (state_q == S_FAULT);
  assign o_pc          = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_instr       = instr_q;
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table for steady-state fetch, backpressure
// and redirect collisions, a fetched-word scoreboard, and hand sequences for corner cases.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] o_pc, i_pc_plus4, o_imem_addr, i_imem_rdata, o_instr, i_redirect_pc, o_fetch_count;
  logic        o_imem_req, i_imem_ack, o_instr_valid, i_instr_ready, i_redirect, o_fault;

  logic [31:0] w_pc, w_pc_plus4, w_addr, w_rdata, w_instr, w_count;
  logic        w_req, w_ack, w_valid, w_ready, w_fault;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  assign i_pc_plus4 = o_pc + 32'd4;
  assign w_pc_plus4 = w_pc + 32'd4;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .o_pc(o_pc), .i_pc_plus4(i_pc_plus4),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata), .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .o_instr(o_instr), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_fault(o_fault), .o_fetch_count(o_fetch_count)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clk(clk), .i_rst_n(i_rst_n), .o_pc(w_pc), .i_pc_plus4(w_pc_plus4),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(w_ack),
    .i_imem_rdata(w_rdata), .o_instr_valid(w_valid), .i_instr_ready(w_ready),
    .o_instr(w_instr), .i_redirect(w_redirect), .i_redirect_pc(w_redirect_pc),
    .o_fault(w_fault), .o_fetch_count(w_count)
  );

  typedef struct {
    logic        ack, ready, redir;
    logic [31:0] rpc;
    logic        e_req, e_valid, e_fault;
    logic [31:0] e_pc, e_instr, e_count;
  } vec_t;

  function automatic vec_t mk(input logic ack, ready, redir, input logic [31:0] rpc,
                              input logic e_req, e_valid, input logic [31:0] e_pc, e_instr, e_count);
    vec_t v;
    v.ack = ack; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_valid = e_valid; v.e_fault = 1'b0;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, update the scoreboard, advance to next falling edge.
  task automatic step(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
    logic [31:0] exp_w;
    i_imem_ack    = ack;
    i_instr_ready = ready;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_imem_rdata  = ack ? (o_imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    #1;
    if (o_imem_req && ack && !redir) sb.push_back(o_imem_addr ^ 32'hA5A5_0000);
    if (o_instr_valid && redir && sb.size() > 0) exp_w = sb.pop_front();
    if (o_instr_valid && ready && !redir) begin
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        exp_w = sb.pop_front();
        chk("sb_instr", o_instr, exp_w);
      end
    end
    @(posedge clk);
    @(negedge clk);
    i_imem_ack = 1'b0; i_instr_ready = 1'b0; i_redirect = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic req, valid, fault,
                           input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_req"},   o_imem_req,    req);
    chk({tag, "_valid"}, o_instr_valid, valid);
    chk({tag, "_fault"}, o_fault,       fault);
    chk({tag, "_pc"},    o_pc,          pc);
    chk({tag, "_addr"},  o_imem_addr,   pc);
    chk({tag, "_count"}, o_fetch_count, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    i_rst_n = 1'b0; i_imem_ack = 1'b0; i_instr_ready = 1'b0; i_redirect = 1'b0;
    i_redirect_pc = 32'd0; i_imem_rdata = 32'd0;
    w_ack = 1'b0; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'd0; w_rdata = 32'd0;

    // sequential fetch, one instruction per two cycles, plus one wait cycle
    vecs.push_back(mk(1,0,0,0, 0,1, 32'h0,  32'hA5A5_0000, 0));
    vecs.push_back(mk(0,1,0,0, 1,0, 32'h4,  32'hA5A5_0000, 1));
    vecs.push_back(mk(1,0,0,0, 0,1, 32'h4,  32'hA5A5_0004, 1));
    vecs.push_back(mk(0,1,0,0, 1,0, 32'h8,  32'hA5A5_0004, 2));
    vecs.push_back(mk(1,0,0,0, 0,1, 32'h8,  32'hA5A5_0008, 2));
    vecs.push_back(mk(0,1,0,0, 1,0, 32'hC,  32'hA5A5_0008, 3));
    vecs.push_back(mk(1,0,0,0, 0,1, 32'hC,  32'hA5A5_000C, 3));
    vecs.push_back(mk(0,1,0,0, 1,0, 32'h10, 32'hA5A5_000C, 4));
    vecs.push_back(mk(0,0,0,0, 1,0, 32'h10, 32'hA5A5_000C, 4));
    vecs.push_back(mk(1,0,0,0, 0,1, 32'h10, 32'hA5A5_0010, 4));
    // backpressure: five cycles with ready low
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,0,0, 0,1, 32'h10, 32'hA5A5_0010, 4));
    vecs.push_back(mk(0,1,0,0, 1,0, 32'h14, 32'hA5A5_0010, 5));
    // redirect colliding with ack, then with ready
    vecs.push_back(mk(1,0,1,32'h100, 1,0, 32'h100, 32'hA5A5_0010, 5));
    vecs.push_back(mk(1,0,0,0,       0,1, 32'h100, 32'hA5A5_0100, 5));
    vecs.push_back(mk(0,1,1,32'h100, 1,0, 32'h100, 32'hA5A5_0100, 5));
    vecs.push_back(mk(1,0,0,0,       0,1, 32'h100, 32'hA5A5_0100, 5));
    vecs.push_back(mk(0,1,0,0,       1,0, 32'h104, 32'hA5A5_0100, 6));

    @(posedge clk);
    @(negedge clk);
    chk_state("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_w_pc", w_pc, 32'hFFFF_FFFC);
    i_rst_n = 1'b1;
    #1;
    chk("rel_req", o_imem_req, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      chk_state($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_fault,
                vecs[i].e_pc, vecs[i].e_count);
      chk($sformatf("v%0d_instr", i), o_instr, vecs[i].e_instr);
    end

    // misaligned redirect traps; later redirects, acks and readies are ignored
    step(0, 0, 1, 32'h102);
    chk_state("mis", 1'b0, 1'b0, 1'b1, 32'h102, 32'd6);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 32'h200);
      chk_state($sformatf("mis_hold%0d", k), 1'b0, 1'b0, 1'b1, 32'h102, 32'd6);
    end
    i_rst_n = 1'b0;
    #1;
    chk("mis_rst_req", o_imem_req, 1'b0);
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk("mis_rst_fault", o_fault, 1'b0);
    chk("mis_rst_pc", o_pc, 32'h0);
    i_rst_n = 1'b1;
    #1;
    chk("mis_rel_req", o_imem_req, 1'b1);

    // reset while holding an instruction with ready asserted
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("mid_count1", o_fetch_count, 32'd1);
    step(1, 0, 0, 0);
    chk("mid_hold", o_instr_valid, 1'b1);
    i_instr_ready = 1'b1;
    i_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk_state("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    chk("mid_rst_instr", o_instr, 32'd0);
    i_instr_ready = 1'b0;
    i_rst_n = 1'b1;

    // PC wrap on the second instance
    w_ack = 1'b1;
    w_rdata = w_addr ^ 32'hA5A5_0000;
    @(posedge clk);
    @(negedge clk);
    w_ack = 1'b0;
    chk("wrap_valid", w_valid, 1'b1);
    chk("wrap_instr", w_instr, 32'h5A5A_FFFC);
    w_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_ready = 1'b0;
    chk("wrap_addr", w_addr, 32'h0000_0000);
    chk("wrap_req", w_req, 1'b1);
    chk("wrap_count", w_count, 32'd1);
    chk("wrap_fault", w_fault, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
